// File: rtl/sysclk_sync_rsp.sv
// Receive end of the sysclk bitcommand sync protocol: captures the command word on the
// phase strobe, emits a delay-trimmed local sync pulse and keeps phase/sync bookkeeping.
module sysclk_sync_rsp #(
  parameter int CMD_BITS   = 4,
  parameter int DELAY_BITS = 8,
  parameter int PERIOD     = 8,
  parameter int PHASE_BITS = 3,
  parameter int EXP_PHASE  = 1,
  parameter int COUNT_BITS = 16
) (
  input  logic                  sysclk_i,
  input  logic                  sysclk_rstn_i,
  input  logic                  sysclk_phase_i,
  input  logic [CMD_BITS-1:0]   bitcommand_i,
  input  logic [DELAY_BITS-1:0] sync_delay_i,
  input  logic                  clear_i,
  output logic                  sync_o,
  output logic [CMD_BITS-2:0]   cmd_o,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  aligned_o,
  output logic [COUNT_BITS-1:0] sync_count_o,
  output logic                  overrun_o,
  output logic                  phase_err_o
);

  typedef enum logic {IDLE, DELAY} state_t;

  localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(PERIOD - 1);
  localparam logic [PHASE_BITS-1:0] PHASE_EXP  = PHASE_BITS'(EXP_PHASE);

  state_t                state_q, state_d;
  logic [DELAY_BITS-1:0] cnt_q, cnt_d;
  logic                  sync_d;
  logic                  overrun_evt;
  logic                  phase_err_evt;
  logic                  sync_cmd;

  assign sync_cmd      = sysclk_phase_i && bitcommand_i[0];
  assign phase_err_evt = aligned_o && sysclk_phase_i && (phase_o != PHASE_EXP);

  // NOTE: every signal gets its default before the case so no path leaves it unassigned
  // (that would infer a latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_d      = 1'b0;
    overrun_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_cmd) begin
          state_d = DELAY;
          cnt_d   = sync_delay_i;
        end
      end
      DELAY: begin
        // A SYNC landing while a delay is pending is dropped, including on the exit cycle.
        overrun_evt = sync_cmd;
        if (cnt_q == '0) begin
          sync_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DELAY_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sync_o       <= 1'b0;
      cmd_o        <= '0;
      phase_o      <= '0;
      aligned_o    <= 1'b0;
      sync_count_o <= '0;
      overrun_o    <= 1'b0;
      phase_err_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_o    <= sync_d;
      cmd_o     <= sysclk_phase_i ? bitcommand_i[CMD_BITS-1:1] : '0;
      aligned_o <= aligned_o | sync_o;

      if (sync_o || phase_o == PHASE_LAST) phase_o <= '0;
      else                                 phase_o <= phase_o + PHASE_BITS'(1);

      // clear takes priority over any coincident set or increment.
      if (clear_i) begin
        sync_count_o <= '0;
        overrun_o    <= 1'b0;
        phase_err_o  <= 1'b0;
      end else begin
        if (sync_o) sync_count_o <= sync_count_o + COUNT_BITS'(1);
        overrun_o   <= overrun_o | overrun_evt;
        phase_err_o <= phase_err_o | phase_err_evt;
      end
    end
  end

endmodule
